// File: rtl/wb_pkg.sv
// Shared types for the writeback/retire unit: result-source encoding and the
// queued register-file write entry.
package wb_pkg;

  localparam int WB_DATA_W = 18;
  localparam int WB_REG_AW = 4;

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_MEM = 2'b01,
    SRC_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic [WB_REG_AW-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/retire_fifo.sv
// Circular retire queue of pending RF writes; all slots are exposed so the
// parent can run an age-ordered forwarding search.
module retire_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic [PW-1:0]         rd_ptr,
  output wb_entry_t [DEPTH-1:0] entries
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // NOTE: storage is deliberately not reset; slots are only meaningful below
  // count, so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_retire_unit.sv
// W-stage result select plus a retire queue that decouples the pipe from a
// busy RF write port. Entry field widths come from wb_pkg.
module writeback_retire_unit
  import wb_pkg::*;
#(
  parameter  int DATA_W   = WB_DATA_W,
  parameter  int REG_AW   = WB_REG_AW,
  parameter  int DEPTH    = 4,
  parameter  int LINK_REG = 15,
  parameter  int ZERO_REG = 1,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidW,
  output logic              ReadyW,
  input  logic              RegWriteW,
  input  logic              BranchLinkW,
  input  logic [1:0]        ResultSrcW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [DATA_W-1:0] ALU_ResultW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [DATA_W-1:0] PCPlus4W,
  output logic [DATA_W-1:0] ResultW,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [REG_AW-1:0] fwd_addr_a,
  input  logic [REG_AW-1:0] fwd_addr_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [CW-1:0]     q_count,
  output logic              overflow_err
);

  logic [DATA_W-1:0]     sel_data;
  logic [REG_AW-1:0]     sel_addr;
  logic                  accept;
  logic                  cand;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [PW-1:0]         rd_ptr;
  wb_entry_t             head;
  wb_entry_t             cand_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DATA_W:0]       fwd_a;
  logic [DATA_W:0]       fwd_b;

  // NOTE: every combinational output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    sel_data = ALU_ResultW;
    sel_addr = RdW;
    if (BranchLinkW) begin
      sel_data = PCPlus4W;
      sel_addr = REG_AW'(LINK_REG);
    end else begin
      case (result_src_e'(ResultSrcW))
        SRC_MEM: sel_data = ReadDataW;
        SRC_PC4: sel_data = PCPlus4W;
        default: sel_data = ALU_ResultW;
      endcase
    end
  end

  assign ResultW    = ValidW ? sel_data : '0;
  assign ReadyW     = !full;
  assign accept     = ValidW && ReadyW;
  assign cand       = accept && (RegWriteW || BranchLinkW) &&
                      !((ZERO_REG != 0) && (sel_addr == '0));
  assign cand_entry = '{addr: sel_addr, data: sel_data};

  // The queue may only be skipped when nothing older is waiting.
  assign pop    = !empty && rf_ready;
  assign bypass = empty && rf_ready && cand;
  assign push   = cand && !bypass;

  assign rf_we    = pop || bypass;
  assign rf_waddr = pop ? head.addr : (bypass ? sel_addr : '0);
  assign rf_wdata = pop ? head.data : (bypass ? sel_data : '0);

  always_ff @(posedge clk) begin
    if (!rst)                overflow_err <= 1'b0;
    else if (ValidW && full) overflow_err <= 1'b1;
  end

  retire_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (cand_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (q_count),
    .rd_ptr     (rd_ptr),
    .entries    (entries)
  );

  // Walks oldest to youngest so later matches overwrite earlier ones; the
  // in-flight candidate is youngest of all. Returns {hit, data}.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [REG_AW-1:0]   a,
    input wb_entry_t [DEPTH-1:0] ents,
    input logic [PW-1:0]       rp,
    input logic [CW-1:0]       cnt,
    input logic                cv,
    input wb_entry_t           ce
  );
    logic              hit;
    logic [DATA_W-1:0] d;
    logic [PW-1:0]     idx;
    hit = 1'b0;
    d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp + PW'(i);
      if ((CW'(i) < cnt) && (ents[idx].addr == a)) begin
        hit = 1'b1;
        d   = ents[idx].data;
      end
    end
    if (cv && (ce.addr == a)) begin
      hit = 1'b1;
      d   = ce.data;
    end
    return {hit, d};
  endfunction

  assign fwd_a      = fwd_lookup(fwd_addr_a, entries, rd_ptr, q_count, cand, cand_entry);
  assign fwd_b      = fwd_lookup(fwd_addr_b, entries, rd_ptr, q_count, cand, cand_entry);
  assign fwd_hit_a  = fwd_a[DATA_W];
  assign fwd_data_a = fwd_a[DATA_W-1:0];
  assign fwd_hit_b  = fwd_b[DATA_W];
  assign fwd_data_b = fwd_b[DATA_W-1:0];

endmodule
